// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between dispatch and commit.
// Define ROB_HEAD_FORWARD_EN to forward a same-cycle finish onto the head outputs.
module reorder_buffer #(
  parameter int SIZE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] instr_in,
  input  logic        finish_instr,
  input  logic [31:0] instr_to_finish,
  input  logic [31:0] finish_val,
  output logic [31:0] head_instr,
  output logic [31:0] head_val,
  output logic        head_ready,
  output logic        is_full,
  output logic        is_empty
);

  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);
  localparam logic [CW-1:0] FULL = CW'(SIZE);

  logic [SIZE-1:0] valid;
  logic [SIZE-1:0] ready;
  logic [31:0]     instr [SIZE];
  logic [31:0]     val   [SIZE];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL);

`ifdef ROB_HEAD_FORWARD_EN
  logic head_hit;
  assign head_hit = finish_instr && valid[head] &&
                    (instr[head] == instr_to_finish);
`endif

  always_comb begin
    head_instr = '0;
    head_val   = '0;
    head_ready = 1'b0;
    if (!is_empty) begin
      head_instr = instr[head];
      head_val   = val[head];
      head_ready = ready[head];
`ifdef ROB_HEAD_FORWARD_EN
      if (head_hit) begin
        head_ready = 1'b1;
        head_val   = finish_val;
      end
`endif
    end
  end

  assign pop_ok  = pop && !is_empty && head_ready;
  assign push_ok = push && (!is_full || pop_ok);

  // Later writes win: push overrides a pop clear on the recycled slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SIZE; i++) begin
        instr[i] <= '0;
        val[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (finish_instr && valid[i] && instr[i] == instr_to_finish) begin
          ready[i] <= 1'b1;
          val[i]   <= finish_val;
        end
      end
      if (pop_ok) begin
        valid[head] <= 1'b0;
        ready[head] <= 1'b0;
        head        <= nxt(head);
      end
      if (push_ok) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        instr[tail] <= instr_in;
        val[tail]   <= '0;
        tail        <= nxt(tail);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (SIZE=10): vector table,
// commit-order scoreboard and asynchronous reset sequence.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] instr_in = '0;
  logic        finish_instr = 1'b0;
  logic [31:0] instr_to_finish = '0;
  logic [31:0] finish_val = '0;
  logic [31:0] head_instr;
  logic [31:0] head_val;
  logic        head_ready;
  logic        is_full;
  logic        is_empty;

  int pass_cnt = 0;
  int total_cnt = 0;

  reorder_buffer #(.SIZE(10)) dut (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .instr_in(instr_in),
    .finish_instr(finish_instr),
    .instr_to_finish(instr_to_finish),
    .finish_val(finish_val),
    .head_instr(head_instr),
    .head_val(head_val),
    .head_ready(head_ready),
    .is_full(is_full),
    .is_empty(is_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        p;
    logic        q;
    logic [31:0] tag;
    logic        f;
    logic [31:0] ftag;
    logic [31:0] fval;
    logic [31:0] hi;
    logic [31:0] hv;
    logic        hr;
    logic        full;
    logic        empty;
  } vec_t;

  typedef struct {
    logic [31:0] tag;
    logic [31:0] v;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic void add(
    input logic p, input logic q, input logic [31:0] tag,
    input logic f, input logic [31:0] ftag, input logic [31:0] fval,
    input logic [31:0] hi, input logic [31:0] hv,
    input logic hr, input logic full, input logic empty);
    vec_t v;
    v.p = p; v.q = q; v.tag = tag;
    v.f = f; v.ftag = ftag; v.fval = fval;
    v.hi = hi; v.hv = hv; v.hr = hr;
    v.full = full; v.empty = empty;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [95:0] got,
                       input logic [95:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, got, exp);
  endtask

  task automatic drive(input logic p, input logic q, input logic [31:0] tag,
                       input logic f, input logic [31:0] ftag,
                       input logic [31:0] fval);
    push = p; pop = q; instr_in = tag;
    finish_instr = f; instr_to_finish = ftag; finish_val = fval;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_head(input string name, input logic [31:0] hi,
                            input logic [31:0] hv, input logic hr,
                            input logic full, input logic empty);
    check(name, {head_instr, head_val, head_ready, is_full, is_empty},
          {hi, hv, hr, full, empty});
  endtask

  initial begin
    int commits;
    int k;
    sb_t e;

    add(0,0,0,   0,0,0,    0,0,0,0,1);
    add(1,0,1,   0,0,0,    1,0,0,0,0);
    add(1,0,2,   0,0,0,    1,0,0,0,0);
    add(1,0,3,   0,0,0,    1,0,0,0,0);
    add(0,1,0,   0,0,0,    1,0,0,0,0);
    add(0,0,0,   1,2,200,  1,0,0,0,0);
    add(0,0,0,   1,1,100,  1,100,1,0,0);
    add(0,1,0,   0,0,0,    2,200,1,0,0);
    add(0,1,0,   0,0,0,    3,0,0,0,0);
    add(0,0,0,   1,3,300,  3,300,1,0,0);
    add(0,1,0,   0,0,0,    0,0,0,0,1);
    add(1,0,5,   1,5,55,   5,0,0,0,0);
    add(0,1,0,   0,0,0,    5,0,0,0,0);
    add(0,0,0,   1,5,56,   5,56,1,0,0);
    add(0,0,0,   1,5,57,   5,57,1,0,0);
    add(1,1,6,   0,0,0,    6,0,0,0,0);
    add(0,0,0,   1,6,66,   6,66,1,0,0);
    add(0,1,0,   0,0,0,    0,0,0,0,1);
    for (int t = 10; t < 19; t++) add(1,0,t, 0,0,0, 10,0,0,0,0);
    add(1,0,19,  0,0,0,    10,0,0,1,0);
    add(1,0,99,  0,0,0,    10,0,0,1,0);
    add(0,0,0,   1,10,1000, 10,1000,1,1,0);
    add(1,1,20,  0,0,0,    11,0,0,1,0);

    repeat (2) @(posedge clock);
    #1;
    check_head("reset_state", 0, 0, 0, 0, 1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].p, vecs[i].q, vecs[i].tag,
            vecs[i].f, vecs[i].ftag, vecs[i].fval);
      step();
      check_head($sformatf("vec%0d", i), vecs[i].hi, vecs[i].hv,
                 vecs[i].hr, vecs[i].full, vecs[i].empty);
    end

    // Drain the full buffer in order; tag 99 must never appear.
    for (int t = 11; t <= 20; t++) begin
      e.tag = t; e.v = t * 2;
      sb.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      e = sb.pop_front();
      drive(0, 0, 0, 1, e.tag, e.v);
      step();
      check($sformatf("drain%0d", i), {head_instr, head_val, head_ready},
            {e.tag, e.v, 1'b1});
      drive(0, 1, 0, 0, 0, 0);
      step();
    end
    check_head("drained", 0, 0, 0, 0, 1);

    // Overlapping push/finish/pop wrapping the pointers several times.
    commits = 0;
    k = 0;
    while (commits < 25 && k < 80) begin
      drive(0, 1, 0, 0, 0, 0);
      if (k < 25) begin
        push = 1'b1;
        instr_in = 200 + k;
        e.tag = 200 + k; e.v = (200 + k) * 3;
        sb.push_back(e);
      end
      if (k >= 3 && k - 3 < 25) begin
        finish_instr = 1'b1;
        instr_to_finish = 200 + k - 3;
        finish_val = (200 + k - 3) * 3;
      end
      if (head_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("commit%0d", commits),
                {head_instr, head_val}, {e.tag, e.v});
        end
        commits++;
      end
      step();
      k++;
    end
    check("commit_count", commits, 25);
    check("sb_empty", sb.size(), 0);
    check_head("wrap_end", 0, 0, 0, 0, 1);

    for (int t = 50; t < 55; t++) begin
      drive(1, 0, t, 0, 0, 0);
      step();
    end
    check_head("held5", 50, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_head("async_reset", 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1, 0, 7, 0, 0, 0);
    step();
    check_head("post_reset_push", 7, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) between dispatch and commit in the out-of-order core.
- Dispatch pushes 32-bit instruction tags in program order. Execution units mark entries finished, with a 32-bit result, by tag lookup.
- Commit pops from the head once the head entry is ready.

Parameters:
- SIZE, 16, number of entries. Any integer ≥2 is legal; non-power-of-two values are required to work (e.g. 10).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- push  in  1  enqueue instr_in at the tail.
- pop  in  1  dequeue the head entry.
- instr_in  in  32  instruction tag to enqueue.
- finish_instr  in  1  completion strobe.
- instr_to_finish  in  32  tag of the completing instruction.
- finish_val  in  32  result value for the completing instruction.
- head_instr  out  32  tag of the head entry.
- head_val  out  32  result of the head entry.
- head_ready  out  1  head entry finished.
- is_full  out  1  count == SIZE.
- is_empty  out  1  count == 0.

Behaviour:
- Storage per entry: valid, ready, instr[31:0], val[31:0].
- State: head pointer, tail pointer, count (0..SIZE).
- Pointers wrap from SIZE-1 to 0.
- Reset (async, active-high):
  - head = tail = count = 0.
  - All valid and ready bits cleared.
  - Outputs: head_instr=0, head_val=0, head_ready=0, is_empty=1, is_full=0.
  - Reset asserted mid-operation discards all entries immediately.
- Head outputs are combinational from the head entry.
  - When empty: head_instr=0, head_val=0, head_ready=0.
- Push accepted when push=1 and (not full, or a pop is accepted in the same cycle).
  - Writes instr_in to tail with valid=1, ready=0, val=0.
  - Tail advances.
  - Push while full with no accepted pop is ignored; no state change.
- Pop accepted when pop=1, not empty, and head_ready=1.
  - Clears the head entry's valid and ready bits; head advances.
  - Pop when empty, or when the head is not ready, is ignored.
- Finish: when finish_instr=1, every valid entry whose instr equals instr_to_finish gets ready=1 and val=finish_val.
  - Applies to entries present before the edge only. An entry pushed in the same cycle is not affected.
  - No match: no effect.
  - Finishing an already-ready entry overwrites its val.
- Simultaneous push+pop: both take effect; count unchanged. This is legal when full (push reuses the freed slot) and when count==1.
- Simultaneous finish+pop on the head: the pop decision uses the pre-edge head_ready.
- count is updated +1 on push-only, -1 on pop-only, unchanged otherwise.
- is_full and is_empty are derived from registered count with no extra latency. Each reflects a push or pop in the cycle after the edge.
- Latency: push to visible-at-head is 1 cycle when empty. Finish to head_ready is 1 cycle (without the optional feature).

Optional Feature:
- Macro: ROB_HEAD_FORWARD_EN.
- Defined:
  - If finish_instr=1 and instr_to_finish matches the valid head entry, head_ready=1 and head_val=finish_val combinationally in the same cycle.
  - A pop in that cycle is accepted.
  - Registered state updates exactly as in the base design.
- Undefined: head_ready and head_val reflect registered state only; finish becomes visible one cycle later.

Test Plan:
- Reset, then idle → is_empty=1, is_full=0, head_instr=0, head_ready=0.
- Push tags 1..3 on consecutive cycles → head_instr=1, head_ready=0, is_empty=0. Then pop with head not ready → ignored, head_instr stays 1.
- Finish tag 2 with val 200, then finish tag 1 with val 100 → head_ready=1, head_val=100.
  - Pop → head_instr=2, head_ready=1, head_val=200.
  - Pop → head_instr=3, head_ready=0.
- SIZE=10: push 10 tags (10..19) → is_full=1.
  - 11th push of tag 99 → ignored; tail unchanged.
  - Finish 10, then push 20 + pop same cycle → is_full stays 1; head_instr=11.
- Wrap-around: with SIZE=10, cycle 25 push/finish/pop triplets → tags commit in push order. is_empty=1 at the end; no stale head_val.
- Assert reset with 5 entries held → is_empty=1 immediately, before the clock edge. Next push of tag 7 → head_instr=7, head_ready=0.
